// File: rtl/ps2_pkg.sv
// ps2_pkg: shared receive-state encoding and PS/2 frame constants
package ps2_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} rx_state_e;
  localparam int PS2_FRAME_BITS = 11;
  localparam logic PS2_IDLE = 1'b1;
endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: synchronous FIFO; a push on a full FIFO is taken only when a pop frees the slot
module byte_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 8
) (
  input  logic                     clk,
  input  logic                     clrn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (!clrn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      if (do_push) mem[wr_ptr] <= din;
    end
  end
endmodule

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host receiver feeding a byte FIFO with ready/nextdata_n pop.
// Define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int SYNC_STAGES = 3,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  rx_state_e state, state_n;
  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic [PS2_FRAME_BITS-1:0] shreg;
  logic [3:0] bit_cnt;
  logic [TW-1:0] to_cnt;
  logic [$clog2(FIFO_DEPTH):0] count;
  logic fall, din, timeout, frame_ok, push, pop, bad, full, empty;
  assign fall = clk_sync[SYNC_STAGES-1] & ~clk_sync[SYNC_STAGES-2];
  assign din = dat_sync[SYNC_STAGES-2];
  assign timeout = state == SHIFT && !fall && to_cnt == TW'(TIMEOUT_CYCLES-1);
  // shreg[0] is the start bit, [8:1] data, [9] parity, [10] stop
  assign frame_ok = !shreg[0] && shreg[PS2_FRAME_BITS-1] && (!PAR_EN || ^shreg[9:1]);
  assign pop = !nextdata_n && !empty;
  assign ready = count != '0;
  always_comb begin
    state_n = state == IDLE  ? (fall ? SHIFT : IDLE) :
              state == SHIFT ? ((fall && bit_cnt == 4'(PS2_FRAME_BITS-2)) ? CHECK : timeout ? IDLE : SHIFT) :
              IDLE;
    push = state == CHECK && frame_ok;
    bad = timeout || (state == CHECK && !frame_ok);
  end
  always_ff @(posedge clk) begin
    if (!clrn) begin
      state <= IDLE;
      clk_sync <= {SYNC_STAGES{PS2_IDLE}};
      dat_sync <= {SYNC_STAGES{PS2_IDLE}};
      shreg <= '0;
      bit_cnt <= '0;
      to_cnt <= '0;
      frame_err <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_n;
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
      if (fall) shreg <= {din, shreg[PS2_FRAME_BITS-1:1]};
      bit_cnt <= state == IDLE ? '0 : fall ? bit_cnt + 1'b1 : bit_cnt;
      to_cnt <= (state != SHIFT || fall) ? '0 : to_cnt + 1'b1;
      frame_err <= bad;
      overflow <= (push && full && nextdata_n) ? 1'b1 : pop ? 1'b0 : overflow;
    end
  end
  byte_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk(clk), .clrn(clrn), .push(push), .pop(pop), .din(shreg[8:1]),
    .dout(data), .full(full), .empty(empty), .count(count)
  );
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: directed table plus hand-written sequences for ps2_rx_fifo
module tb_ps2_rx_fifo;
  localparam int TO = 5000;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  typedef struct {
    logic [7:0] b;
    logic start;
    logic flip;
    logic stop;
    logic ok;
  } vec_t;
  logic clk = 1'b0, clrn = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1, nextdata_n = 1'b1;
  logic [7:0] data;
  logic ready, overflow, frame_err, fe_prev = 1'b0;
  int checks = 0, errors = 0, fe_cnt = 0, fe_wide = 0, fe0;
  vec_t tbl [7];

  ps2_rx_fifo #(.FIFO_DEPTH(8), .SYNC_STAGES(3), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .nextdata_n(nextdata_n),
    .data(data), .ready(ready), .overflow(overflow), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (frame_err && fe_prev) fe_wide++;
    fe_prev = frame_err;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] mk(input logic [7:0] b, input logic start, input logic flip, input logic stop);
    return {stop, ~^b ^ flip, b, start};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      repeat (4) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (4) @(negedge clk);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [10:0] f);
    send_bits(f, 11);
    repeat (4) @(negedge clk);
  endtask

  task automatic pop1;
    nextdata_n = 1'b0;
    @(negedge clk);
    nextdata_n = 1'b1;
  endtask

  initial begin
    tbl[0] = '{8'h1C, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[1] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[2] = '{8'hFF, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[3] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{8'h32, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[5] = '{8'h7E, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{8'h1C, 1'b0, 1'b1, 1'b1, !PAR};
    repeat (3) @(negedge clk);
    check("rst_ready", ready, 0);
    check("rst_overflow", overflow, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_data", data, 0);
    clrn = 1'b1;
    repeat (3) @(negedge clk);

    send_bits(mk(8'h1C, 0, 0, 1), 10);
    ps2_data = 1'b1;
    repeat (4) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (3) @(negedge clk);
    check("lat_early_ready", ready, 0);
    @(negedge clk);
    check("lat_ready", ready, 1);
    check("lat_data", data, 8'h1C);
    repeat (4) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (4) @(negedge clk);
    check("lat_no_frame_err", fe_cnt, 0);
    pop1;
    check("lat_pop_empty", ready, 0);

    for (int i = 0; i < 7; i++) begin
      fe0 = fe_cnt;
      send_frame(mk(tbl[i].b, tbl[i].start, tbl[i].flip, tbl[i].stop));
      check($sformatf("vec%0d_ready", i), ready, tbl[i].ok);
      if (tbl[i].ok) check($sformatf("vec%0d_data", i), data, tbl[i].b);
      check($sformatf("vec%0d_frame_err", i), fe_cnt - fe0, 32'(!tbl[i].ok));
      if (ready) pop1;
      check($sformatf("vec%0d_drained", i), ready, 0);
    end

    send_frame(mk(8'hF0, 0, 0, 1));
    send_frame(mk(8'h1C, 0, 0, 1));
    check("drain_head", data, 8'hF0);
    check("drain_ready", ready, 1);
    nextdata_n = 1'b0;
    @(negedge clk);
    check("drain_second", data, 8'h1C);
    check("drain_second_ready", ready, 1);
    @(negedge clk);
    check("drain_empty", ready, 0);
    check("drain_empty_data", data, 0);
    @(negedge clk);
    check("drain_extra_pop", ready, 0);
    nextdata_n = 1'b1;
    check("drain_no_overflow", overflow, 0);

    for (int i = 1; i <= 9; i++) begin
      send_frame(mk(8'(i), 0, 0, 1));
      if (i == 8) check("ovf_full_no_flag", overflow, 0);
    end
    check("ovf_set", overflow, 1);
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("ovf_data%0d", i), data, i);
      pop1;
      if (i == 1) check("ovf_clear_on_pop", overflow, 0);
    end
    check("ovf_drained", ready, 0);

    fe0 = fe_cnt;
    send_bits(mk(8'h1C, 0, 0, 1), 5);
    repeat (TO - 50) @(negedge clk);
    check("to_not_yet", fe_cnt - fe0, 0);
    repeat (100) @(negedge clk);
    check("to_pulse", fe_cnt - fe0, 1);
    check("to_no_write", ready, 0);
    send_frame(mk(8'h1C, 0, 0, 1));
    check("to_next_ready", ready, 1);
    check("to_next_data", data, 8'h1C);
    check("to_next_no_err", fe_cnt - fe0, 1);
    pop1;

    for (int i = 0; i < 9; i++) send_frame(mk(8'(8'h40 + i), 0, 0, 1));
    check("rstmid_ovf_before", overflow, 1);
    send_bits(mk(8'hAA, 0, 0, 1), 5);
    clrn = 1'b0;
    @(negedge clk);
    check("rstmid_ready", ready, 0);
    check("rstmid_overflow", overflow, 0);
    check("rstmid_data", data, 0);
    check("rstmid_frame_err", frame_err, 0);
    clrn = 1'b1;
    repeat (2) @(negedge clk);
    send_frame(mk(8'h1C, 0, 0, 1));
    check("rstmid_next_data", data, 8'h1C);
    pop1;
    check("rstmid_single_byte", ready, 0);

    check("frame_err_width", fe_wide, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
